// File: rtl/dmem_arbiter.sv
// Two-port fixed-priority arbiter in front of the single-port data memory.
// Port 0 (LSU) wins by default; a starvation counter hands port 1 a slot after STARVE_LIMIT denials.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [2:0]  p0_funct3,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [2:0]  p1_funct3,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_resp_valid,
  output logic        p0_resp_err,
  output logic        p1_resp_valid,
  output logic        p1_resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             p0_rv_reg, p0_rv_next;
  logic             p1_rv_reg, p1_rv_next;
  logic             p0_err_reg, p0_err_next;
  logic             p1_err_reg, p1_err_next;
  logic [31:0]      rdata_reg, rdata_next;

  logic starve;
  logic grant0, grant1, accept;
  logic sel_we, sel_mis;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = (a == 2'b11);
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  assign starve = (cnt_reg >= LIMIT);

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (p1_valid && (starve || !p0_valid)) grant1 = 1'b1;
      else if (p0_valid)                     grant0 = 1'b1;
    end
  end

  assign accept   = grant0 | grant1;
  assign p0_ready = grant0;
  assign p1_ready = grant1;

  always_comb begin
    mem_funct3 = p0_funct3;
    mem_addr   = p0_addr;
    mem_wdata  = p0_wdata;
    sel_we     = p0_we;
    if (grant1) begin
      mem_funct3 = p1_funct3;
      mem_addr   = p1_addr;
      mem_wdata  = p1_wdata;
      sel_we     = p1_we;
    end
  end

  assign sel_mis = misaligned(mem_funct3, mem_addr[1:0]);
  assign mem_we  = accept & sel_we & ~sel_mis;

  always_comb begin
    cnt_next    = '0;
    p0_rv_next  = grant0;
    p1_rv_next  = grant1;
    p0_err_next = grant0 & sel_mis;
    p1_err_next = grant1 & sel_mis;
    rdata_next  = rdata_reg;
    if (p1_valid && !grant1)
      cnt_next = starve ? LIMIT : cnt_reg + 1'b1;
    // Stores and rejected accesses return zero; read data only from aligned loads.
    if (accept)
      rdata_next = (!sel_we && !sel_mis) ? mem_rdata : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      p0_rv_reg  <= 1'b0;
      p1_rv_reg  <= 1'b0;
      p0_err_reg <= 1'b0;
      p1_err_reg <= 1'b0;
      rdata_reg  <= 32'h0;
    end else begin
      cnt_reg    <= cnt_next;
      p0_rv_reg  <= p0_rv_next;
      p1_rv_reg  <= p1_rv_next;
      p0_err_reg <= p0_err_next;
      p1_err_reg <= p1_err_next;
      rdata_reg  <= rdata_next;
    end
  end

  assign p0_resp_valid = p0_rv_reg;
  assign p1_resp_valid = p1_rv_reg;
  assign p0_resp_err   = p0_err_reg;
  assign p1_resp_err   = p1_err_reg;
  assign resp_rdata    = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small byte-addressable memory model.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        p0_valid, p0_ready, p0_we;
  logic [2:0]  p0_funct3;
  logic [31:0] p0_addr, p0_wdata;
  logic        p1_valid, p1_ready, p1_we;
  logic [2:0]  p1_funct3;
  logic [31:0] p1_addr, p1_wdata;
  logic        p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.STARVE_LIMIT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_funct3(p0_funct3),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_funct3(p1_funct3),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_err(p0_resp_err),
    .p1_resp_valid(p1_resp_valid), .p1_resp_err(p1_resp_err),
    .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, clocked byte/half/word write.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

  always_comb begin
    logic [31:0] w;
    logic [31:0] sh;
    w  = mem[mem_addr[9:2]];
    sh = w >> (8 * mem_addr[1:0]);
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{sh[7]}}, sh[7:0]};
      3'b100:  mem_rdata = {24'h0, sh[7:0]};
      3'b001:  mem_rdata = {{16{sh[15]}}, sh[15:0]};
      3'b101:  mem_rdata = {16'h0, sh[15:0]};
      default: mem_rdata = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        int lane;
        lane = b - int'(mem_addr[1:0]);
        if (lane >= 0 && ((mem_funct3[1:0] == 2'b00 && lane < 1) ||
                          (mem_funct3[1:0] == 2'b01 && lane < 2) ||
                          (mem_funct3[1:0] == 2'b10 && lane < 4)))
          mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*lane +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        p0v, p0we;
    logic [2:0]  p0f3;
    logic [31:0] p0a, p0d;
    logic        p1v, p1we;
    logic [2:0]  p1f3;
    logic [31:0] p1a, p1d;
    logic        er0, er1, ewe, erv0, erv1, eerr;
    logic [31:0] erd;
  } vec_t;

  task automatic drive(input logic v0, we0, input logic [2:0] f0, input logic [31:0] a0, d0,
                       input logic v1, we1, input logic [2:0] f1, input logic [31:0] a1, d1);
    p0_valid = v0; p0_we = we0; p0_funct3 = f0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = we1; p1_funct3 = f1; p1_addr = a1; p1_wdata = d1;
  endtask

  vec_t vecs [17];

  initial begin
    //            p0: v we f3     addr          wdata          p1: v we f3   addr          wdata          r0 r1 we rv0 rv1 err rdata
    vecs[0]  = '{1,1,3'b010,32'h100,32'hCAFEBABE, 0,0,3'b010,32'h0,  32'h0,   1,0,1, 1,0,0, 32'h0};
    vecs[1]  = '{1,0,3'b010,32'h100,32'h0,        0,0,3'b010,32'h0,  32'h0,   1,0,0, 1,0,0, 32'hCAFEBABE};
    vecs[2]  = '{0,0,3'b010,32'h100,32'h0,        0,0,3'b010,32'h0,  32'h0,   0,0,0, 0,0,0, 32'hCAFEBABE};
    vecs[3]  = '{0,0,3'b010,32'h0,  32'h0,        1,0,3'b010,32'h102,32'h0,   0,1,0, 0,1,1, 32'h0};
    vecs[4]  = '{0,0,3'b010,32'h0,  32'h0,        1,1,3'b001,32'h103,32'h1234,0,1,0, 0,1,1, 32'h0};
    vecs[5]  = '{0,0,3'b010,32'h0,  32'h0,        1,0,3'b010,32'h100,32'h0,   0,1,0, 0,1,0, 32'hCAFEBABE};
    vecs[6]  = '{0,0,3'b010,32'h0,  32'h0,        1,1,3'b000,32'h105,32'hAA,  0,1,1, 0,1,0, 32'h0};
    vecs[7]  = '{0,0,3'b010,32'h0,  32'h0,        1,0,3'b100,32'h105,32'h0,   0,1,0, 0,1,0, 32'h000000AA};
    vecs[8]  = '{0,0,3'b010,32'h0,  32'h0,        1,0,3'b000,32'h105,32'h0,   0,1,0, 0,1,0, 32'hFFFFFFAA};
    vecs[9]  = '{1,0,3'b010,32'h100,32'h0,        0,0,3'b010,32'h0,  32'h0,   1,0,0, 1,0,0, 32'hCAFEBABE};
    vecs[10] = '{0,0,3'b010,32'h0,  32'h0,        1,0,3'b010,32'h104,32'h0,   0,1,0, 0,1,0, 32'h0000AA00};
    vecs[11] = '{1,0,3'b001,32'h106,32'h0,        1,0,3'b010,32'h104,32'h0,   1,0,0, 1,0,0, 32'h0};
    vecs[12] = '{1,0,3'b001,32'h104,32'h0,        0,0,3'b010,32'h0,  32'h0,   1,0,0, 1,0,0, 32'hFFFFAA00};
    vecs[13] = '{1,1,3'b010,32'h101,32'h55555555, 0,0,3'b010,32'h0,  32'h0,   1,0,0, 1,0,1, 32'h0};
    vecs[14] = '{1,0,3'b011,32'h100,32'h0,        0,0,3'b010,32'h0,  32'h0,   1,0,0, 1,0,1, 32'h0};
    vecs[15] = '{1,0,3'b010,32'h100,32'h0,        0,0,3'b010,32'h0,  32'h0,   1,0,0, 1,0,0, 32'hCAFEBABE};
    vecs[16] = '{0,0,3'b010,32'h0,  32'h0,        0,0,3'b010,32'h0,  32'h0,   0,0,0, 0,0,0, 32'hCAFEBABE};

    // Reset held with a pending store: nothing may be granted or written.
    rst = 1'b1;
    drive(1,1,3'b010,32'h200,32'h0, 0,0,3'b010,32'h0,32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_p0_ready", {31'h0, p0_ready}, 32'd0);
    chk("rst_p1_ready", {31'h0, p1_ready}, 32'd0);
    chk("rst_mem_we",   {31'h0, mem_we},   32'd0);
    chk("rst_rv",       {30'h0, p0_resp_valid, p1_resp_valid}, 32'd0);
    chk("rst_err",      {30'h0, p0_resp_err, p1_resp_err}, 32'd0);
    chk("rst_rdata",    resp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_p0_ready", {31'h0, p0_ready}, 32'd1);
    chk("post_rst_mem_we",   {31'h0, mem_we},   32'd1);
    @(posedge clk); #1;
    chk("post_rst_rv0", {31'h0, p0_resp_valid}, 32'd1);
    $display("reset release: p0 sw 0x200 granted, rv0=%0b", p0_resp_valid);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].p0v, vecs[i].p0we, vecs[i].p0f3, vecs[i].p0a, vecs[i].p0d,
            vecs[i].p1v, vecs[i].p1we, vecs[i].p1f3, vecs[i].p1a, vecs[i].p1d);
      #1;
      chk($sformatf("v%0d_p0_ready", i), {31'h0, p0_ready}, {31'h0, vecs[i].er0});
      chk($sformatf("v%0d_p1_ready", i), {31'h0, p1_ready}, {31'h0, vecs[i].er1});
      chk($sformatf("v%0d_mem_we", i),   {31'h0, mem_we},   {31'h0, vecs[i].ewe});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rv0", i),  {31'h0, p0_resp_valid}, {31'h0, vecs[i].erv0});
      chk($sformatf("v%0d_rv1", i),  {31'h0, p1_resp_valid}, {31'h0, vecs[i].erv1});
      chk($sformatf("v%0d_err0", i), {31'h0, p0_resp_err}, {31'h0, vecs[i].erv0 & vecs[i].eerr});
      chk($sformatf("v%0d_err1", i), {31'h0, p1_resp_err}, {31'h0, vecs[i].erv1 & vecs[i].eerr});
      chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].erd);
      $display("vec %0d: ready=%0b%0b we=%0b rv=%0b%0b err=%0b%0b rdata=%h", i,
               p0_ready, p1_ready, mem_we, p0_resp_valid, p1_resp_valid,
               p0_resp_err, p1_resp_err, resp_rdata);
    end
    chk("mem_0x100_intact", mem[32'h100 >> 2], 32'hCAFEBABE);

    // Reset mid-operation: response dropped at once, starvation count cleared.
    @(negedge clk);
    drive(1,0,3'b010,32'h100,32'h0, 1,0,3'b010,32'h104,32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rv0_before", {31'h0, p0_resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rv0",   {31'h0, p0_resp_valid}, 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_ready", {30'h0, p0_ready, p1_ready}, 32'd0);
    $display("mid-transfer reset: rv0=%0b rdata=%h", p0_resp_valid, resp_rdata);
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention: p1 gets every 9th slot, counter starts from zero.
    for (int c = 1; c <= 27; c++) begin
      logic exp1;
      exp1 = (c % 9 == 0);
      #1;
      chk($sformatf("prio_c%0d_p1_ready", c), {31'h0, p1_ready}, {31'h0, exp1});
      chk($sformatf("prio_c%0d_p0_ready", c), {31'h0, p0_ready}, {31'h0, ~exp1});
      @(posedge clk); #1;
      chk($sformatf("prio_c%0d_rv1", c), {31'h0, p1_resp_valid}, {31'h0, exp1});
      chk($sformatf("prio_c%0d_rdata", c), resp_rdata, exp1 ? 32'h0000AA00 : 32'hCAFEBABE);
      $display("prio cycle %0d: ready=%0b%0b rv=%0b%0b rdata=%h", c,
               p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, resp_rdata);
      @(negedge clk);
    end
    drive(0,0,3'b010,32'h0,32'h0, 0,0,3'b010,32'h0,32'h0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Grants one access per cycle with fixed priority to port 0, plus a starvation counter that guarantees port 1 progress.
- Drives the memory's combinational-read / clocked-write interface and returns registered responses tagged to the owning port. Misaligned accesses are screened before they reach memory.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles port 1 may be pending-and-denied before it takes priority; legal range 1..255.
- CNT_W, 8: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- p0_valid / p1_valid  in  1  request valid
- p0_ready / p1_ready  out  1  request accepted this cycle (combinational)
- p0_we / p1_we  in  1  1 = store, 0 = load
- p0_funct3 / p1_funct3  in  3  access size/sign, RISC-V load/store encoding
- p0_addr / p1_addr  in  32  byte address
- p0_wdata / p1_wdata  in  32  store data, LSB-aligned
- p0_resp_valid / p1_resp_valid  out  1  one-cycle response pulse
- p0_resp_err / p1_resp_err  out  1  misaligned access, qualified by resp_valid
- resp_rdata  out  32  shared load data, qualified by either resp_valid
- mem_we  out  1  memory write enable
- mem_funct3  out  3  to memory
- mem_addr  out  32  to memory
- mem_wdata  out  32  to memory
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, rst=1):
  - p0/p1_resp_valid=0, p0/p1_resp_err=0, resp_rdata=0.
  - Starvation counter=0, starve flag=0.
  - All ready outputs and mem_we are forced 0 while rst=1.
- Arbitration (combinational, every cycle):
  - starve = (cnt >= STARVE_LIMIT).
  - Winner is port 1 if p1_valid and (starve or !p0_valid); otherwise port 0 if p0_valid; otherwise none.
  - Exactly the winner's ready=1; the loser's ready=0.
- Memory drive:
  - mem_addr, mem_funct3 and mem_wdata mux the winner's fields.
  - With no winner they hold the port-0 fields; mem_we=0.
- Write gating: mem_we = winner exists & winner.we & aligned.
- Alignment rules:
  - funct3[1:0]=00 (byte) is always aligned.
  - funct3[1:0]=01 (half) is misaligned iff addr[1:0]=11.
  - funct3[1:0]=10 (word) is misaligned iff addr[1:0]!=00.
  - funct3[1:0]=11 is treated as misaligned.
- Response (1-cycle latency): at the posedge that completes an accept, register:
  - owner's resp_valid=1;
  - resp_err = misaligned;
  - resp_rdata = (load & aligned) ? mem_rdata : 32'h0 (stores and errors return 0).
  - Pulses last exactly one cycle. resp_rdata holds its value until the next accept.
- Back-to-back: accepts may occur on consecutive cycles, with no bubble. A response for cycle N's accept and a grant for cycle N+1 coexist.
- Starvation counter:
  - p1_valid & !p1_ready: cnt increments, saturating at STARVE_LIMIT.
  - p1 accepted or p1_valid=0: cnt clears to 0.
- Simultaneous events:
  - Store and load never share a cycle, so no read-after-write hazard exists inside the arbiter.
  - A load accepted the cycle after a store to the same word sees the stored data.
- Reset mid-operation: a pending response is dropped (resp_valid=0 immediately) and the counter clears. Requesters must re-issue.
- MMIO/tohost addresses are passed through unchanged; decoding belongs to memory.

Test Plan:
- Reset: assert rst mid-transfer with p0_valid=1 -> all resp_valid/err=0, mem_we=0 and both ready=0 while rst=1; first grant goes to p0 in the first cycle after release.
- Single store/load: p0 sw 0x00000100 <- 0xCAFEBABE, then lw 0x00000100 -> p0_ready asserted in each accept cycle, p0_resp_valid one cycle later, resp_rdata=0xCAFEBABE, err=0.
- Priority: p0 and p1 both valid continuously, STARVE_LIMIT=8 -> p0 wins 8 cycles, p1 is granted in cycle 9, counter returns to 0, p0 resumes in cycle 10. Repeats with period 9.
- Misalignment: p1 lw addr 0x102, then sh addr 0x103 -> mem_we stays 0 for both, p1_resp_err=1, resp_rdata=0; memory word at 0x100 is unchanged.
- Byte/half via port 1: sb 0x105 <- 0xAA, then lbu 0x105 -> rdata=0x000000AA; lb 0x105 -> rdata=0xFFFFFFAA.
- Back-to-back alternating owners: p0 load at cycle N, p1 load at cycle N+1 -> p0_resp_valid at N+1, p1_resp_valid at N+2, each with the correct rdata and no overlap.
